// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the EX stage and the iterative
// multiply/divide unit.
//   srca, srcb  operands (dividend/multiplicand/MTHI-MTLO data, divisor/multiplier)
//   mduop       0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   start       request strobe; mduop/srca/srcb sampled when high
//   busy        operation in flight
//   done        one-cycle pulse when hi/lo take a mult/div result
//   hi, lo      architectural HI/LO registers
// master = requester (EX stage), slave = mdu_iter.
interface mdu_iter_if;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [2:0]  mduop;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output srca, srcb, mduop, start,
    input  busy, done, hi, lo
  );

  modport slave (
    input  srca, srcb, mduop, start,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit holding HI/LO.
// The full result is computed at accept time and parked in pend_hi/pend_lo;
// a down-counter then models the iterative latency before HI/LO are written.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mdu_iter_if.slave (operands, op, start, busy, done, hi, lo)
module mdu_iter #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset_n,
  mdu_iter_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t MultCnt = cnt_t'(MULT_CYCLES);
  localparam cnt_t DivCnt  = cnt_t'(DIV_CYCLES);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;
  logic        done_q, done_d;

  // Multiply: the low 64 bits of the sign-extended product are the signed product.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{32{bus.srca[31]}}, bus.srca};
  assign b_sx   = {{32{bus.srcb[31]}}, bus.srcb};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, bus.srca} * {32'd0, bus.srcb};

  // Divide: a zero divisor is swapped for 1 so the dividers never see it; the
  // result is discarded anyway. Signed divide works on magnitudes, so
  // 0x80000000 / -1 wraps to 0x80000000 with no special case.
  logic        div_zero;
  logic [31:0] divisor, quo_u, rem_u;
  logic [31:0] mag_a, mag_b, quo_mag, rem_mag, quo_s, rem_s;
  assign div_zero = (bus.srcb == 32'd0);
  assign divisor  = div_zero ? 32'd1 : bus.srcb;
  assign quo_u    = bus.srca / divisor;
  assign rem_u    = bus.srca % divisor;
  assign mag_a    = bus.srca[31] ? -bus.srca : bus.srca;
  assign mag_b    = divisor[31] ? -divisor : divisor;
  assign quo_mag  = mag_a / mag_b;
  assign rem_mag  = mag_a % mag_b;
  assign quo_s    = (bus.srca[31] ^ divisor[31]) ? -quo_mag : quo_mag;
  assign rem_s    = bus.srca[31] ? -rem_mag : rem_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.mduop)
            OpMult: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_dz_d = 1'b0;
              cnt_d     = MultCnt;
              state_d   = StRun;
            end
            OpMultu: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_dz_d = 1'b0;
              cnt_d     = MultCnt;
              state_d   = StRun;
            end
            OpDiv: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              pend_dz_d = div_zero;
              cnt_d     = DivCnt;
              state_d   = StRun;
            end
            OpDivu: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_dz_d = div_zero;
              cnt_d     = DivCnt;
              state_d   = StRun;
            end
            OpMthi:  hi_d = bus.srca;
            OpMtlo:  lo_d = bus.srca;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Requests arriving here are dropped; the pipeline stalls on start|busy.
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter. Inputs change and outputs are
// sampled on the falling edge; expected HI/LO/latency come from a reference
// model and travel through a scoreboard queue until the matching done pulse.
module tb_mdu_iter;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  exp_t        sb_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mdu_iter_if bus ();

  mdu_iter #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: predicts HI/LO after a mult/div and queues the expectation.
  task automatic push_expect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, p, q, r;
    logic [63:0] pu;
    e.hi = model_hi;
    e.lo = model_lo;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    case (op)
      OpMult: begin
        p    = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      OpMultu: begin
        pu   = {32'd0, a} * {32'd0, b};
        e.hi = pu[63:32];
        e.lo = pu[31:0];
      end
      OpDiv: begin
        if (b != 32'd0) begin
          q    = sa / sb;
          r    = sa % sb;
          e.hi = r[31:0];
          e.lo = q[31:0];
        end
      end
      OpDivu: begin
        if (b != 32'd0) begin
          e.hi = a % b;
          e.lo = a / b;
        end
      end
      default: ;
    endcase
    e.lat    = (op == OpMult || op == OpMultu) ? 5 : 10;
    model_hi = e.hi;
    model_lo = e.lo;
    sb_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.mduop = op;
    bus.srca  = a;
    bus.srcb  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mduop = OpNop;
  endtask

  // Waits (bounded) for done, counting busy cycles and watching HI/LO for early change.
  task automatic wait_done(output int bcyc, output bit tmo, output bit moved);
    logic [31:0] h0, l0;
    h0    = bus.hi;
    l0    = bus.lo;
    bcyc  = 0;
    moved = 1'b0;
    for (int i = 0; i < 100 && bus.done !== 1'b1; i++) begin
      if (bus.busy === 1'b1) bcyc++;
      if (bus.hi !== h0 || bus.lo !== l0) moved = 1'b1;
      @(negedge clk);
    end
    tmo = (bus.done !== 1'b1);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.mduop = OpNop;
    bus.srca  = '0;
    bus.srcb  = '0;
    model_hi  = '0;
    model_lo  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++;
    if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    checks++;
    if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [2:0]  ops[7];
    logic [31:0] as[7];
    logic [31:0] bs[7];
    exp_t        e;
    int          bc;
    bit          tmo, mv;
    ops = '{OpMult, OpMultu, OpDiv, OpDivu, OpDiv, OpMult, OpDiv};
    as  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
            $urandom(), $urandom()};
    bs  = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, $urandom(), $urandom() | 32'd1};
    for (int i = 0; i < 7; i++) begin
      push_expect(ops[i], as[i], bs[i]);
      issue(ops[i], as[i], bs[i]);
      wait_done(bc, tmo, mv);
      e = sb_q.pop_front();
      checks++;
      if (tmo) begin failures++; $display("FAIL arith%0d_timeout got no done want done", i); end
      checks++;
      if (bc !== e.lat) begin failures++; $display("FAIL arith%0d_latency got %0d want %0d", i, bc, e.lat); end
      checks++;
      if (bus.hi !== e.hi) begin failures++; $display("FAIL arith%0d_hi got %h want %h", i, bus.hi, e.hi); end
      checks++;
      if (bus.lo !== e.lo) begin failures++; $display("FAIL arith%0d_lo got %h want %h", i, bus.lo, e.lo); end
      checks++;
      if (mv) begin failures++; $display("FAIL arith%0d_early_hilo got changed want held", i); end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL arith%0d_done_pulse got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_mt_divzero();
    exp_t e;
    int   bc;
    bit   tmo, mv;
    issue(OpMthi, 32'h0000_1234, 32'd0);
    model_hi = 32'h0000_1234;
    checks++;
    if (bus.hi !== 32'h1234 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mthi got hi=%h busy=%b done=%b want 1234 0 0", bus.hi, bus.busy, bus.done);
    end
    issue(OpMtlo, 32'h0000_5678, 32'd0);
    model_lo = 32'h0000_5678;
    checks++;
    if (bus.lo !== 32'h5678 || bus.hi !== 32'h1234 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo got hi=%h lo=%h busy=%b want 1234 5678 0", bus.hi, bus.lo, bus.busy);
    end
    push_expect(OpDiv, 32'h0000_0099, 32'd0);
    issue(OpDiv, 32'h0000_0099, 32'd0);
    wait_done(bc, tmo, mv);
    e = sb_q.pop_front();
    checks++;
    if (tmo || bc !== e.lat) begin
      failures++;
      $display("FAIL divzero_latency got %0d (timeout %b) want %0d", bc, tmo, e.lat);
    end
    checks++;
    if (bus.hi !== e.hi || bus.lo !== e.lo) begin
      failures++;
      $display("FAIL divzero_hilo got %h/%h want %h/%h", bus.hi, bus.lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_in_run();
    exp_t e;
    int   bc, pre;
    bit   tmo, mv;
    push_expect(OpMult, 32'h0001_0003, 32'hFFFF_0007);
    bus.mduop = OpMult;
    bus.srca  = 32'h0001_0003;
    bus.srcb  = 32'hFFFF_0007;
    bus.start = 1'b1;
    @(negedge clk);
    // Hold start high for the whole run, first with a DIV then with MTLO.
    bus.mduop = OpDiv;
    bus.srca  = 32'd100;
    bus.srcb  = 32'd7;
    pre = 0;
    repeat (2) begin
      if (bus.busy === 1'b1) pre++;
      @(negedge clk);
    end
    bus.mduop = OpMtlo;
    bus.srca  = 32'h0000_AAAA;
    wait_done(bc, tmo, mv);
    bus.start = 1'b0;
    bus.mduop = OpNop;
    e = sb_q.pop_front();
    checks++;
    if (tmo || pre + bc !== e.lat) begin
      failures++;
      $display("FAIL ignore_latency got %0d (timeout %b) want %0d", pre + bc, tmo, e.lat);
    end
    checks++;
    if (bus.hi !== e.hi || bus.lo !== e.lo) begin
      failures++;
      $display("FAIL ignore_hilo got %h/%h want %h/%h", bus.hi, bus.lo, e.hi, e.lo);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.lo !== e.lo || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_after got busy=%b lo=%h done=%b want 0 %h 0", bus.busy, bus.lo,
               bus.done, e.lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[2];
    logic [31:0] as[2];
    logic [31:0] bs[2];
    exp_t        e;
    int          bc;
    bit          tmo, mv;
    ops = '{OpMultu, OpDivu};
    as  = '{32'hDEAD_BEEF, 32'hFFFF_FFF0};
    bs  = '{32'h0000_1001, 32'h0000_0013};
    // The second request goes in on the first edge after done appears.
    for (int i = 0; i < 2; i++) begin
      push_expect(ops[i], as[i], bs[i]);
      issue(ops[i], as[i], bs[i]);
      wait_done(bc, tmo, mv);
      e = sb_q.pop_front();
      checks++;
      if (tmo || bc !== e.lat) begin
        failures++;
        $display("FAIL b2b%0d_latency got %0d (timeout %b) want %0d", i, bc, tmo, e.lat);
      end
      checks++;
      if (bus.hi !== e.hi || bus.lo !== e.lo) begin
        failures++;
        $display("FAIL b2b%0d_hilo got %h/%h want %h/%h", i, bus.hi, bus.lo, e.hi, e.lo);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    bit changed;
    issue(OpMthi, 32'hDEAD_0001, 32'd0);
    model_hi = 32'hDEAD_0001;
    issue(OpDiv, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", bus.hi,
               bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    model_hi = '0;
    model_lo = '0;
    dones    = 0;
    changed  = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (bus.hi !== model_hi || bus.lo !== model_lo || bus.busy !== 1'b0) changed = 1'b1;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL midreset_done got %0d pulses want 0", dones); end
    checks++;
    if (changed) begin
      failures++;
      $display("FAIL midreset_late_write got hi=%h lo=%h want 0 0", bus.hi, bus.lo);
    end
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_arith();
    test_mt_divzero();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the pipelined MIPS core. It sits in the EX stage beside the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO requests from the ALU operand bus (SrcA/SrcB), holds the architectural HI/LO registers, and reports Busy so hazard logic can stall later HI/LO users. Results appear after a fixed multi-cycle latency, modelling a real iterative datapath.

## Interface
- MULT_CYCLES, 5, cycles from accept to HI/LO update for MULT/MULTU (≥1)
- DIV_CYCLES, 10, cycles from accept to HI/LO update for DIV/DIVU (≥1)

- clk  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous and active-low
- SrcA  in  32  operand A (dividend / multiplicand / MTHI-MTLO data)
- SrcB  in  32  operand B (divisor / multiplier)
- MDUOp  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NOP)
- Start  in  1  request strobe; MDUOp/SrcA/SrcB sampled when high
- Busy  out  1  operation in flight
- Done  out  1  one-cycle pulse when HI/LO take a mult/div result
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, RUN. Down-counter Cnt, width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Reset (reset_n=0, asynchronous): state IDLE, Cnt=0, HI=0, LO=0, Busy=0, Done=0, pending result regs=0. Reset mid-RUN aborts; no late write.
- IDLE + Start + op 1–4: compute the full result from the sampled operands into PendHI/PendLO, set Cnt=MULT_CYCLES or DIV_CYCLES, go to RUN.
- IDLE + Start + op 5/6: write SrcA into HI (5) or LO (6) at that edge. Stay IDLE; Busy and Done stay 0.
- IDLE + Start + op 0/7, or Start=0: no effect.
- RUN: decrement Cnt each edge. On the edge where Cnt goes 1→0, write HI=PendHI and LO=PendLO (unless div-by-zero), return to IDLE, and pulse Done.
- Start during RUN: ignored entirely, including MTHI/MTLO. Upstream stall logic must hold the request (stall on Start|Busy).
- MULT: signed 32×32→64, {HI,LO}=product. MULTU: unsigned.
- DIV: signed, quotient truncated toward zero, remainder takes the dividend's sign. LO=quotient, HI=remainder. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (32-bit wrap, no trap).
- Divide by zero (SrcB=0, DIV or DIVU): full DIV_CYCLES latency, Busy and Done behave normally, HI/LO unchanged.
- HI/LO are never written except as listed above.

## Timing
- Accept at edge k: Busy=1 after edges k … k+N−1, where N is the op latency.
- Edge k+N: HI/LO update, Busy→0, Done=1 for the cycle after edge k+N only.
- A new Start is accepted at edge k+N+1 at the earliest: a Start sampled at edge k+N sees RUN and is ignored. There is no back-to-back accept.
- MTHI/MTLO: HI/LO visible in the cycle after the accept edge. Zero latency beyond the register.
- Busy and Done are registered; no combinational path from Start to any output.
- HI/LO hold their old values throughout RUN; intermediate values are never visible.

## Test plan
- Reset, then MULT SrcA=0xFFFFFFFE (−2), SrcB=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done pulses once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2 -> Busy 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000 / −1 -> LO=0x80000000, HI=0.
- Preload MTHI 0x1234, MTLO 0x5678, then DIV x/0 -> Busy 10 cycles, Done pulses, HI=0x1234, LO=0x5678 unchanged.
- MULT accepted, then MTLO 0xAAAA and DIV requested during RUN -> both ignored; final HI/LO equal the MULT product; Busy low exactly 5 cycles after accept.
- DIV accepted, reset_n pulsed low at cycle 4 -> HI=LO=0 and Busy=0 immediately; no write or Done afterwards.
